// File: rtl/multi_pulse_counter_pkg.sv
// rtl/multi_pulse_counter_pkg.sv - shared constants, types and helpers for multi_pulse_counter
//
// Package mpc_pkg:
//   CH_MAX, SYNC_MIN, SYNC_MAX   legal parameter limits
//   BUS_MAX                      widest packed per-channel bus (CH_MAX channels x 32 bits)
//   upd_op_e                     decoded per-channel counter operation
//   cnt_max(width)               all-ones value of a width-bit counter
//   ch_slice(bus, ch, width)     channel slice of a packed bus, zero-extended to 32 bits
package mpc_pkg;

    localparam int CH_MAX   = 16;
    localparam int SYNC_MIN = 2;
    localparam int SYNC_MAX = 4;
    localparam int BUS_MAX  = CH_MAX * 32;

    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_INC  = 2'd1,
        OP_DEC  = 2'd2,
        OP_CLR  = 2'd3
    } upd_op_e;

    // Computed in 64 bits so that width=32 does not overflow the shift.
    function automatic logic [31:0] cnt_max(input int width);
        logic [63:0] w_full;
        w_full = (64'd1 << width) - 64'd1;
        return w_full[31:0];
    endfunction

    function automatic logic [31:0] ch_slice(input logic [BUS_MAX-1:0] bus,
                                             input int                 ch,
                                             input int                 width);
        logic [BUS_MAX-1:0] w_shift;
        w_shift = bus >> (ch * width);
        return w_shift[31:0] & cnt_max(width);
    endfunction

endpackage

// File: rtl/multi_pulse_counter_toggle_sync_edge.sv
// rtl/multi_pulse_counter_toggle_sync_edge.sv - toggle synchroniser and edge detector
//
// Module toggle_sync_edge: brings one toggle-encoded signal into dst_clk,
// then turns each level change into a one-cycle event.
//   dst_clk  in   counting clock
//   dst_rst  in   asynchronous active-high reset
//   tog      in   toggle from a foreign clock domain
//   arm      in   event enable; synchroniser and delay flop load regardless
//   evt      out  one-cycle event per level change of tog
module toggle_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic dst_clk,
    input  logic dst_rst,
    input  logic tog,
    input  logic arm,
    output logic evt
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_dly;

    always_ff @(posedge dst_clk or posedge dst_rst) begin
        if (dst_rst) begin
            r_sync <= '0;
            r_dly  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], tog};
            r_dly  <= r_sync[SYNC_STAGES-1];
        end
    end

    // While disarmed the delay flop still tracks the synchronised level, so a
    // toggle already high at reset release becomes the baseline, not an event.
    assign evt = arm & (r_sync[SYNC_STAGES-1] ^ r_dly);

endmodule

// File: rtl/multi_pulse_counter.sv
// rtl/multi_pulse_counter.sv - multi-channel saturating up/down counter of cross-domain toggle events
//
// Optional feature macro: MULTI_PULSE_COUNTER_THRESH_EN (adds thresh input and thresh_hit comparators).
//   dst_clk     in   counting clock
//   dst_rst     in   asynchronous active-high reset
//   inc_tog     in   per-channel increment toggles (foreign domain)
//   dec_tog     in   per-channel decrement toggles (foreign domain)
//   clr         in   per-channel synchronous count clear
//   err_clr     in   clears all sticky error bits
//   thresh      in   packed per-channel thresholds (only with the macro)
//   pulse_num   out  packed counts, channel i at [i*WID_16 +: WID_16]
//   empty/full  out  per-channel count==0 / count==max
//   ovf_err     out  sticky: increment rejected at full
//   unf_err     out  sticky: decrement rejected at empty
//   thresh_hit  out  registered count>=thresh (0 without the macro)
module multi_pulse_counter
    import mpc_pkg::*;
#(
    parameter int CH_NUM      = 4,
    parameter int WID_16      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     dst_clk,
    input  logic                     dst_rst,
    input  logic [CH_NUM-1:0]        inc_tog,
    input  logic [CH_NUM-1:0]        dec_tog,
    input  logic [CH_NUM-1:0]        clr,
    input  logic                     err_clr,
`ifdef MULTI_PULSE_COUNTER_THRESH_EN
    input  logic [CH_NUM*WID_16-1:0] thresh,
`endif
    output logic [CH_NUM*WID_16-1:0] pulse_num,
    output logic [CH_NUM-1:0]        empty,
    output logic [CH_NUM-1:0]        full,
    output logic [CH_NUM-1:0]        ovf_err,
    output logic [CH_NUM-1:0]        unf_err,
    output logic [CH_NUM-1:0]        thresh_hit
);

    localparam int SYNC_EFF = (SYNC_STAGES < SYNC_MIN) ? SYNC_MIN :
                              (SYNC_STAGES > SYNC_MAX) ? SYNC_MAX : SYNC_STAGES;
    localparam logic [2:0]        ARM_DONE  = 3'(SYNC_EFF + 1);
    localparam logic [31:0]       CNT_MAX32 = cnt_max(WID_16);
    localparam logic [WID_16-1:0] CNT_MAX   = CNT_MAX32[WID_16-1:0];
    localparam logic [WID_16-1:0] CNT_ONE   = WID_16'(1);

    logic [2:0] r_arm_cnt;
    logic       w_arm;

    // Masks events for the first SYNC_EFF+1 edges after reset release, long
    // enough for the synchroniser and delay flop to settle on the source level.
    always_ff @(posedge dst_clk or posedge dst_rst) begin
        if (dst_rst) begin
            r_arm_cnt <= 3'd0;
        end else if (r_arm_cnt != ARM_DONE) begin
            r_arm_cnt <= r_arm_cnt + 3'd1;
        end
    end

    assign w_arm = (r_arm_cnt == ARM_DONE);

`ifdef MULTI_PULSE_COUNTER_THRESH_EN
    logic [BUS_MAX-1:0] w_thresh_ext;

    always_comb begin
        w_thresh_ext = '0;
        w_thresh_ext[CH_NUM*WID_16-1:0] = thresh;
    end
`endif

    for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
        logic              w_inc;
        logic              w_dec;
        upd_op_e           w_op;
        logic [WID_16-1:0] r_cnt;
        logic [WID_16-1:0] w_cnt_nxt;
        logic              w_ovf_set;
        logic              w_unf_set;
        logic              r_empty;
        logic              r_full;
        logic              r_ovf;
        logic              r_unf;

        toggle_sync_edge #(.SYNC_STAGES(SYNC_EFF)) u_inc_sync (
            .dst_clk (dst_clk),
            .dst_rst (dst_rst),
            .tog     (inc_tog[i]),
            .arm     (w_arm),
            .evt     (w_inc)
        );

        toggle_sync_edge #(.SYNC_STAGES(SYNC_EFF)) u_dec_sync (
            .dst_clk (dst_clk),
            .dst_rst (dst_rst),
            .tog     (dec_tog[i]),
            .arm     (w_arm),
            .evt     (w_dec)
        );

        // Clear beats everything; coincident inc and dec cancel to a hold.
        always_comb begin
            w_op = OP_HOLD;
            if (clr[i]) begin
                w_op = OP_CLR;
            end else if (w_inc && !w_dec) begin
                w_op = OP_INC;
            end else if (w_dec && !w_inc) begin
                w_op = OP_DEC;
            end
        end

        always_comb begin
            w_cnt_nxt = r_cnt;
            w_ovf_set = 1'b0;
            w_unf_set = 1'b0;
            case (w_op)
                OP_CLR: w_cnt_nxt = '0;
                OP_INC: begin
                    if (r_cnt == CNT_MAX) begin
                        w_ovf_set = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_ONE;
                    end
                end
                OP_DEC: begin
                    if (r_cnt == '0) begin
                        w_unf_set = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_ONE;
                    end
                end
                default: w_cnt_nxt = r_cnt;
            endcase
        end

        // Flags derive from the next count so they change on the same edge as it.
        always_ff @(posedge dst_clk or posedge dst_rst) begin
            if (dst_rst) begin
                r_cnt   <= '0;
                r_empty <= 1'b1;
                r_full  <= 1'b0;
                r_ovf   <= 1'b0;
                r_unf   <= 1'b0;
            end else begin
                r_cnt   <= w_cnt_nxt;
                r_empty <= (w_cnt_nxt == '0);
                r_full  <= (w_cnt_nxt == CNT_MAX);
                r_ovf   <= w_ovf_set | (r_ovf & ~err_clr);
                r_unf   <= w_unf_set | (r_unf & ~err_clr);
            end
        end

        assign pulse_num[i*WID_16 +: WID_16] = r_cnt;
        assign empty[i]   = r_empty;
        assign full[i]    = r_full;
        assign ovf_err[i] = r_ovf;
        assign unf_err[i] = r_unf;

`ifdef MULTI_PULSE_COUNTER_THRESH_EN
        logic [31:0] w_thr;
        logic [31:0] w_cnt32;
        logic        r_hit;

        assign w_thr   = ch_slice(w_thresh_ext, i, WID_16);
        assign w_cnt32 = 32'(r_cnt);

        always_ff @(posedge dst_clk or posedge dst_rst) begin
            if (dst_rst) begin
                r_hit <= 1'b0;
            end else begin
                r_hit <= (w_cnt32 >= w_thr);
            end
        end

        assign thresh_hit[i] = r_hit;
`else
        assign thresh_hit[i] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_multi_pulse_counter.sv
// tb/tb_multi_pulse_counter.sv - self-checking bench for multi_pulse_counter
module tb_multi_pulse_counter;

    localparam int CH = 4;
    localparam int W  = 8;
    localparam int S  = 2;
    localparam logic [W-1:0] MAX = '1;

    logic            dst_clk = 1'b0;
    logic            dst_rst;
    logic [CH-1:0]   inc_tog;
    logic [CH-1:0]   dec_tog;
    logic [CH-1:0]   clr;
    logic            err_clr;
    logic [CH*W-1:0] pulse_num;
    logic [CH-1:0]   empty;
    logic [CH-1:0]   full;
    logic [CH-1:0]   ovf_err;
    logic [CH-1:0]   unf_err;
    logic [CH-1:0]   thresh_hit;
`ifdef MULTI_PULSE_COUNTER_THRESH_EN
    logic [CH*W-1:0] thresh;
`endif

    multi_pulse_counter #(
        .CH_NUM      (CH),
        .WID_16      (W),
        .SYNC_STAGES (S)
    ) dut (
        .dst_clk    (dst_clk),
        .dst_rst    (dst_rst),
        .inc_tog    (inc_tog),
        .dec_tog    (dec_tog),
        .clr        (clr),
        .err_clr    (err_clr),
`ifdef MULTI_PULSE_COUNTER_THRESH_EN
        .thresh     (thresh),
`endif
        .pulse_num  (pulse_num),
        .empty      (empty),
        .full       (full),
        .ovf_err    (ovf_err),
        .unf_err    (unf_err),
        .thresh_hit (thresh_hit)
    );

    always #5 dst_clk = ~dst_clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [W-1:0] m_cnt [CH];
    logic         m_ovf [CH];
    logic         m_unf [CH];

    typedef struct {
        string        tag;
        int           ch;
        logic [W-1:0] cnt;
        logic         emp;
        logic         ful;
        logic         ovf;
        logic         unf;
    } exp_t;

    exp_t sb[$];

    task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_cnt[c] = '0;
            m_ovf[c] = 1'b0;
            m_unf[c] = 1'b0;
        end
    endtask

    // Flip source toggles and advance the reference model by the resulting event.
    task automatic tog(input int ch, input bit do_inc, input bit do_dec);
        if (do_inc) inc_tog[ch] = ~inc_tog[ch];
        if (do_dec) dec_tog[ch] = ~dec_tog[ch];
        if (do_inc && !do_dec) begin
            if (m_cnt[ch] == MAX) m_ovf[ch] = 1'b1;
            else                  m_cnt[ch] = m_cnt[ch] + 1'b1;
        end else if (do_dec && !do_inc) begin
            if (m_cnt[ch] == '0) m_unf[ch] = 1'b1;
            else                 m_cnt[ch] = m_cnt[ch] - 1'b1;
        end
    endtask

    task automatic push_exp(input string tag, input int ch);
        sb.push_back('{tag, ch, m_cnt[ch], (m_cnt[ch] == '0), (m_cnt[ch] == MAX), m_ovf[ch], m_unf[ch]});
    endtask

    task automatic push_all(input string tag);
        for (int c = 0; c < CH; c++) push_exp(tag, c);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            cmp({e.tag, ".cnt"},   32'(pulse_num[e.ch*W +: W]), 32'(e.cnt));
            cmp({e.tag, ".empty"}, 32'(empty[e.ch]),   32'(e.emp));
            cmp({e.tag, ".full"},  32'(full[e.ch]),    32'(e.ful));
            cmp({e.tag, ".ovf"},   32'(ovf_err[e.ch]), 32'(e.ovf));
            cmp({e.tag, ".unf"},   32'(unf_err[e.ch]), 32'(e.unf));
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) @(negedge dst_clk);
    endtask

    initial begin
        dst_rst = 1'b1;
        inc_tog = '0;
        dec_tog = '0;
        clr     = '0;
        err_clr = 1'b0;
`ifdef MULTI_PULSE_COUNTER_THRESH_EN
        thresh  = '1;
`endif
        inc_tog[0] = 1'b1;
        model_reset();
        ticks(3);
        push_all("rst");
        drain();
        cmp("rst.thit", 32'(thresh_hit), 32'd0);

        // Source already high at release is a baseline, not an event.
        dst_rst = 1'b0;
        ticks(8);
        push_exp("base0", 0);
        drain();

        // Five increments on ch1; the last one also checks exact latency.
        for (int k = 0; k < 4; k++) begin
            tog(1, 1'b1, 1'b0);
            ticks(4);
        end
        tog(1, 1'b1, 1'b0);
        ticks(1);
        cmp("lat.n", 32'(pulse_num[1*W +: W]), 32'd4);
        ticks(1);
        cmp("lat.n1", 32'(pulse_num[1*W +: W]), 32'd4);
        ticks(1);
        push_exp("inc5", 1);
        drain();
        ticks(1);
        tog(1, 1'b0, 1'b1);
        ticks(4);
        tog(1, 1'b0, 1'b1);
        ticks(4);
        push_exp("dec2", 1);
        drain();

        // Fill ch2 to all-ones, then overflow.
        for (int k = 0; k < int'(MAX); k++) begin
            tog(2, 1'b1, 1'b0);
            ticks(2);
        end
        ticks(2);
        push_exp("fill", 2);
        drain();
        tog(2, 1'b1, 1'b0);
        ticks(4);
        push_exp("ovf", 2);
        drain();
        err_clr = 1'b1;
        ticks(1);
        err_clr = 1'b0;
        m_ovf[2] = 1'b0;
        ticks(1);
        push_exp("errclr", 2);
        drain();

        // err_clr on the very edge an overflow is flagged: the set must win.
        tog(2, 1'b1, 1'b0);
        ticks(2);
        err_clr = 1'b1;
        ticks(1);
        err_clr = 1'b0;
        push_exp("setwins", 2);
        drain();
        ticks(2);

        // ch0: coincident inc/dec, then clear racing an inc event.
        tog(0, 1'b1, 1'b0);
        ticks(4);
        tog(0, 1'b1, 1'b0);
        ticks(4);
        push_exp("ch0_2", 0);
        drain();
        tog(0, 1'b1, 1'b1);
        ticks(4);
        push_exp("incdec", 0);
        drain();
        tog(0, 1'b1, 1'b0);
        ticks(2);
        clr[0] = 1'b1;
        ticks(1);
        clr[0] = 1'b0;
        m_cnt[0] = '0;
        push_exp("clrdrop", 0);
        drain();
        ticks(3);
        push_exp("clrdrop2", 0);
        drain();

        // Asynchronous reset mid-count, checked before any clock edge.
        #3;
        dst_rst = 1'b1;
        #1;
        model_reset();
        push_all("arst");
        drain();
        cmp("arst.thit", 32'(thresh_hit), 32'd0);
        ticks(2);
        dst_rst = 1'b0;
        ticks(8);
        push_all("rearm");
        drain();

        // Decrement at empty after a fresh reset.
        tog(3, 1'b0, 1'b1);
        ticks(4);
        push_exp("unf", 3);
        drain();

`ifdef MULTI_PULSE_COUNTER_THRESH_EN
        thresh[1*W +: W] = 8'd3;
        tog(1, 1'b1, 1'b0);
        ticks(4);
        tog(1, 1'b1, 1'b0);
        ticks(4);
        cmp("thr.below", 32'(thresh_hit[1]), 32'd0);
        tog(1, 1'b1, 1'b0);
        ticks(3);
        cmp("thr.cnt", 32'(pulse_num[1*W +: W]), 32'd3);
        cmp("thr.lag", 32'(thresh_hit[1]), 32'd0);
        ticks(1);
        cmp("thr.hit", 32'(thresh_hit[1]), 32'd1);
`else
        cmp("thit.tied", 32'(thresh_hit), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multi_pulse_counter.md
Name: multi_pulse_counter

Overview:
- Parametrised successor to the single-channel async pulse counter: CH_NUM independent up/down event counters in the dst_clk domain.
- Each channel takes toggle-encoded increment and decrement events from foreign clock domains. Every toggle is synchronised, edge-detected and accumulated with saturation.
- Adds sticky over/underflow errors, per-channel clear, a post-reset arming window and empty/full flags.
- Sits between producer/consumer domains (e.g. motion-pulse generators) and dst_clk control logic that needs outstanding-pulse counts.

Parameters:
- CH_NUM, 4: number of independent channels (1..16).
- WID_16, 16: counter width per channel (2..32).
- SYNC_STAGES, 2: synchroniser flops per toggle input (2..4).

Ports:
- dst_clk  input  1  counting clock.
- dst_rst  input  1  asynchronous, active-high reset.
- inc_tog  input  CH_NUM  per-channel increment toggle from a foreign domain; each level change is one event.
- dec_tog  input  CH_NUM  per-channel decrement toggle from a foreign domain; each level change is one event.
- clr  input  CH_NUM  per-channel synchronous clear, dst_clk domain.
- err_clr  input  1  clears all sticky error bits.
- pulse_num  output  CH_NUM*WID_16  packed counts; channel i occupies bits [i*WID_16 +: WID_16].
- empty  output  CH_NUM  count==0 per channel.
- full  output  CH_NUM  count==2^WID_16-1 per channel.
- ovf_err  output  CH_NUM  sticky: increment rejected at full.
- unf_err  output  CH_NUM  sticky: decrement rejected at empty.
- thresh_hit  output  CH_NUM  see Optional Feature.

Behaviour:
- Reset values: pulse_num=0, empty=all 1, full=0, ovf_err=0, unf_err=0, thresh_hit=0. All synchroniser and delay flops=0, arm counter=0.
- Sync path per toggle bit: SYNC_STAGES flops, then one delay flop. event = last_stage XOR delay.
- Latency: a toggle change captured at dst_clk edge n updates pulse_num at edge n+SYNC_STAGES.
- Arming window: after dst_rst deasserts, events are masked for the first SYNC_STAGES+1 edges. During this window the synchronisers and delay flops still load.
  - Consequence: a source toggle that is non-zero at reset release is taken as baseline, not counted as an event.
  - A 3-bit arm counter saturates at SYNC_STAGES+1. Reset mid-operation re-enters the window.
- Per-channel update, priority order:
  1. clr[i]=1: count=0 and events this cycle are dropped.
  2. inc and dec both set: count unchanged (net zero, no error).
  3. inc only: count+1. If already full, count holds and ovf_err[i] is set.
  4. dec only: count-1. If already empty, count holds at 0 and unf_err[i] is set.
- Arithmetic: no wrap-around under any input.
- Error flags:
  - Error set in the same cycle as err_clr: set wins.
  - err_clr does not affect counts.
- empty and full are registered alongside the count, with zero extra latency relative to pulse_num.
- Event rate limit: at most one toggle change per source per 2 dst_clk cycles. Faster toggling loses events. This is a documented requirement on the source, not detected by the block.
- Channels are fully independent; no cross-channel arbitration.

Optional Feature:
- Macro: MULTI_PULSE_COUNTER_THRESH_EN.
- Defined:
  - Adds input thresh  CH_NUM*WID_16  (packed, dst_clk domain, quasi-static).
  - thresh_hit[i] is registered count_i >= thresh_i, updating one edge after pulse_num.
  - Reset value 0.
- Undefined:
  - thresh port absent.
  - thresh_hit tied to 0.
  - No comparators synthesised.

Decomposition:
- Package mpc_pkg holds:
  - CH_MAX=16, SYNC_MIN=2, SYNC_MAX=4.
  - Function cnt_max(width) returning 2^width-1.
  - Function to extract a channel slice from the packed bus.
- Sub-module toggle_sync_edge (params SYNC_STAGES):
  - Single-bit synchroniser plus delay flop.
  - Inputs: dst_clk, dst_rst, tog, arm. Output: one-cycle event.
  - Instantiated 2*CH_NUM times.
- Top level holds:
  - the arm counter;
  - per-channel saturating counter, flags and errors via generate loop.

Test Plan:
- Reset release with inc_tog[0]=1 already high, no further toggles -> pulse_num ch0 stays 0, no error.
- Toggle inc_tog[1] five times, 4 cycles apart -> ch1=5 at edge n+2 after the last toggle capture (SYNC_STAGES=2); then toggle dec_tog[1] twice -> ch1=3.
- Increment ch2 to 0xFFFF (WID_16=16), then one more inc toggle -> ch2 holds 0xFFFF, full[2]=1, ovf_err[2]=1. Pulse err_clr -> ovf_err[2]=0, count unchanged.
- Fresh reset, dec toggle on ch3 -> ch3 stays 0, unf_err[3]=1, empty[3]=1.
- Inc and dec toggles on ch0 arriving in the same cycle -> count unchanged. clr[0] coincident with an inc event -> count=0, event dropped.
- With MULTI_PULSE_COUNTER_THRESH_EN, thresh ch1=3: counts 2->3 -> thresh_hit[1] rises one edge after pulse_num reaches 3. Assert dst_rst mid-count -> all outputs return to reset values asynchronously.
